fir_serial_mac: RTL and testbench

FIR_SERIAL_MAC -- requirements
Module: fir_serial_mac

---
 rtl/fir_pkg.sv | 19 +
 rtl/fir_round_sat.sv | 37 +++
 rtl/fir_serial_mac.sv | 114 +++++++++++
 tb/tb_fir_serial_mac.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FSM state type and width helpers for the serial FIR
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_OUT
    } state_e;

    // Sum of N products each DW+CW wide cannot overflow with log2(N) guard bits.
    function automatic int acc_width(input int dw, input int cw, input int n);
        return dw + cw + $clog2(n);
    endfunction

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// rtl/fir_round_sat.sv - round-half-up, arithmetic shift and clamp of the accumulator
module fir_round_sat #(
    parameter int ACC_WIDTH  = 35,
    parameter int DATA_WIDTH = 16,
    parameter int OUT_SHIFT  = 14
) (
    input  logic signed [ACC_WIDTH-1:0]  acc_i,
    output logic signed [DATA_WIDTH-1:0] y_o,
    output logic                         sat_o
);

    localparam logic signed [ACC_WIDTH-1:0] HALF =
        {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (OUT_SHIFT - 1);
    localparam logic signed [ACC_WIDTH-1:0] MAX_V =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MIN_V =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] rounded;
    logic signed [ACC_WIDTH-1:0] shifted;

    assign rounded = acc_i + HALF;
    assign shifted = rounded >>> OUT_SHIFT;

    always_comb begin
        y_o   = shifted[DATA_WIDTH-1:0];
        sat_o = 1'b0;
        if (shifted > MAX_V) begin
            y_o   = MAX_V[DATA_WIDTH-1:0];
            sat_o = 1'b1;
        end else if (shifted < MIN_V) begin
            y_o   = MIN_V[DATA_WIDTH-1:0];
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/fir_serial_mac.sv
// rtl/fir_serial_mac.sv - N-tap FIR with a single time-shared multiply-accumulate
module fir_serial_mac
    import fir_pkg::*;
#(
    parameter int N_TAPS      = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int OUT_SHIFT   = 14
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic signed [DATA_WIDTH-1:0]          x_in,
    input  logic                                  coef_we,
    input  logic        [cnt_width(N_TAPS)-1:0]   coef_addr,
    input  logic signed [COEFF_WIDTH-1:0]         coef_data,
    input  logic                                  out_ready,
    output logic                                  out_valid,
    output logic signed [DATA_WIDTH-1:0]          y_out,
    output logic                                  sat_flag
);

    localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, COEFF_WIDTH, N_TAPS);
    localparam int CNT_WIDTH  = cnt_width(N_TAPS);
    localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;
    localparam logic [CNT_WIDTH-1:0] K_LAST = CNT_WIDTH'(N_TAPS - 1);
    localparam logic [COEFF_WIDTH-1:0] H_UNITY =
        {{(COEFF_WIDTH-1){1'b0}}, 1'b1} << OUT_SHIFT;

    state_e                        state_q;
    logic signed [DATA_WIDTH-1:0]  x_q [N_TAPS];
    logic signed [COEFF_WIDTH-1:0] h_q [N_TAPS];
    logic signed [ACC_WIDTH-1:0]   acc_q;
    logic signed [ACC_WIDTH-1:0]   acc_d;
    logic        [CNT_WIDTH-1:0]   k_q;
    logic signed [DATA_WIDTH-1:0]  y_q;
    logic                          sat_q;
    logic signed [PROD_WIDTH-1:0]  prod;
    logic signed [DATA_WIDTH-1:0]  rs_y;
    logic                          rs_sat;

    // Operands widened to the full product width so the multiply is exact.
    assign prod = $signed({{COEFF_WIDTH{x_q[k_q][DATA_WIDTH-1]}}, x_q[k_q]})
                * $signed({{DATA_WIDTH{h_q[k_q][COEFF_WIDTH-1]}}, h_q[k_q]});
    assign acc_d = acc_q + {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};

    // Fed from acc_d so the last product is included when OUT is entered.
    fir_round_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_round_sat (
        .acc_i(acc_d),
        .y_o  (rs_y),
        .sat_o(rs_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            k_q     <= '0;
            y_q     <= '0;
            sat_q   <= 1'b0;
            for (int i = 0; i < N_TAPS; i++) begin
                x_q[i] <= '0;
                h_q[i] <= '0;
            end
            h_q[0] <= H_UNITY;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    for (int i = 0; i < N_TAPS; i++) begin
                        if (coef_we && coef_addr == CNT_WIDTH'(i)) begin
                            h_q[i] <= coef_data;
                        end
                    end
                    if (in_valid) begin
                        x_q[0] <= x_in;
                        for (int i = 1; i < N_TAPS; i++) begin
                            x_q[i] <= x_q[i-1];
                        end
                        acc_q   <= '0;
                        k_q     <= '0;
                        state_q <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc_q <= acc_d;
                    if (k_q == K_LAST) begin
                        y_q     <= rs_y;
                        sat_q   <= rs_sat;
                        state_q <= ST_OUT;
                    end else begin
                        k_q <= k_q + CNT_WIDTH'(1);
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_OUT);
    assign y_out     = y_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_fir_serial_mac.sv
// tb/tb_fir_serial_mac.sv - directed self-checking bench for fir_serial_mac
module tb_fir_serial_mac;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] x_in = '0;
    logic               coef_we = 1'b0;
    logic        [2:0]  coef_addr = '0;
    logic signed [15:0] coef_data = '0;
    logic               out_ready = 1'b1;
    logic               out_valid;
    logic signed [15:0] y_out;
    logic               sat_flag;

    int n_checks = 0;
    int n_fail   = 0;

    fir_serial_mac #(
        .N_TAPS(8), .DATA_WIDTH(16), .COEFF_WIDTH(16), .OUT_SHIFT(14)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .out_ready(out_ready), .out_valid(out_valid),
        .y_out(y_out), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_coef(input logic [2:0] a, input logic signed [15:0] d);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // Offers one sample, returns the result seen with out_valid and the
    // number of negedges from acceptance until out_valid was observed.
    task automatic run_sample(input logic signed [15:0] x, output logic signed [15:0] y,
                              output logic s, output int lat);
        @(negedge clk);
        in_valid = 1'b1; x_in = x;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (!out_valid) begin
            n_fail++;
            $display("FAIL run_sample_timeout: out_valid=%0b required 1 for x=%0d", out_valid, x);
        end
        y = y_out; s = sat_flag;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        n_checks += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
        if (y_out !== 16'sd0) begin n_fail++; $display("FAIL reset_y_out: got %0d required 0", y_out); end
        if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %0b required 0", sat_flag); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
    endtask

    task automatic test_identity();
        logic signed [15:0] y; logic s; int lat;
        run_sample(16'sd1000, y, s, lat);
        n_checks += 3;
        if (y !== 16'sd1000) begin n_fail++; $display("FAIL identity_y: got %0d required 1000", y); end
        if (s !== 1'b0) begin n_fail++; $display("FAIL identity_sat: got %0b required 0", s); end
        if (lat != 9) begin n_fail++; $display("FAIL identity_latency: got %0d required 9", lat); end
    endtask

    task automatic test_two_tap();
        logic signed [15:0] y; logic s; int lat;
        logic signed [15:0] xs [3];
        logic signed [15:0] ex [3];
        xs = '{16'sd100, 16'sd0, 16'sd0};
        ex = '{16'sd100, 16'sd100, 16'sd0};
        do_reset();
        write_coef(3'd1, 16'sd16384);
        for (int i = 0; i < 3; i++) begin
            run_sample(xs[i], y, s, lat);
            n_checks++;
            if (y !== ex[i]) begin n_fail++; $display("FAIL two_tap_%0d: got %0d required %0d", i, y, ex[i]); end
        end
    endtask

    task automatic test_saturation();
        logic signed [15:0] y; logic s; int lat;
        do_reset();
        for (int i = 0; i < 8; i++) write_coef(3'(i), 16'sd16384);
        for (int i = 0; i < 8; i++) begin
            run_sample(16'sd32767, y, s, lat);
            if (i == 0) begin
                n_checks += 2;
                if (y !== 16'sd32767) begin n_fail++; $display("FAIL sat_first_y: got %0d required 32767", y); end
                if (s !== 1'b0) begin n_fail++; $display("FAIL sat_first_flag: got %0b required 0", s); end
            end
        end
        n_checks += 2;
        if (y !== 16'sd32767) begin n_fail++; $display("FAIL sat_pos_y: got %0d required 32767", y); end
        if (s !== 1'b1) begin n_fail++; $display("FAIL sat_pos_flag: got %0b required 1", s); end
        for (int i = 0; i < 8; i++) run_sample(-16'sd32768, y, s, lat);
        n_checks += 2;
        if (y !== -16'sd32768) begin n_fail++; $display("FAIL sat_neg_y: got %0d required -32768", y); end
        if (s !== 1'b1) begin n_fail++; $display("FAIL sat_neg_flag: got %0b required 1", s); end
    endtask

    task automatic test_rounding();
        logic signed [15:0] y; logic s; int lat;
        logic signed [15:0] xs [3];
        logic signed [15:0] ex [3];
        xs = '{16'sd8192, 16'sd8191, -16'sd8193};
        ex = '{16'sd1, 16'sd0, -16'sd1};
        do_reset();
        write_coef(3'd0, 16'sd1);
        for (int i = 0; i < 3; i++) begin
            run_sample(xs[i], y, s, lat);
            n_checks += 2;
            if (y !== ex[i]) begin n_fail++; $display("FAIL round_%0d: got %0d required %0d", i, y, ex[i]); end
            if (s !== 1'b0) begin n_fail++; $display("FAIL round_sat_%0d: got %0b required 0", i, s); end
        end
    endtask

    task automatic test_backpressure();
        logic signed [15:0] y; logic s; int lat;
        do_reset();
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; x_in = 16'sd500;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin @(negedge clk); lat++; end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; x_in = 16'sd7777;
            coef_we = 1'b1; coef_addr = 3'(c % 2); coef_data = 16'sd0;
            @(negedge clk);
            n_checks += 3;
            if (y_out !== 16'sd500) begin n_fail++; $display("FAIL stall_y_%0d: got %0d required 500", c, y_out); end
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready_%0d: got %0b required 0", c, in_ready); end
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid_%0d: got %0b required 1", c, out_valid); end
        end
        in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        write_coef(3'd1, 16'sd16384);
        run_sample(16'sd3, y, s, lat);
        n_checks++;
        if (y !== 16'sd503) begin n_fail++; $display("FAIL stall_history: got %0d required 503", y); end
    endtask

    task automatic test_reset_mid_mac();
        logic signed [15:0] y; logic s; int lat; int seen;
        do_reset();
        write_coef(3'd1, 16'sd16384);
        run_sample(16'sd700, y, s, lat);
        @(negedge clk);
        in_valid = 1'b1; x_in = 16'sd900;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midmac_out_valid: got %0b required 0", out_valid); end
        if (y_out !== 16'sd0) begin n_fail++; $display("FAIL midmac_y_out: got %0d required 0", y_out); end
        if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL midmac_sat: got %0b required 0", sat_flag); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL midmac_abandon: got %0d out_valid cycles required 0", seen); end
        run_sample(16'sd50, y, s, lat);
        n_checks++;
        if (y !== 16'sd50) begin n_fail++; $display("FAIL midmac_fresh: got %0d required 50", y); end
    endtask

    task automatic test_back_to_back();
        int t0; int t1; int cyc;
        logic signed [15:0] y0; logic signed [15:0] y1;
        do_reset();
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; x_in = 16'sd11;
        t0 = -1; t1 = -1; y0 = '0; y1 = '0; cyc = 0;
        while (t1 < 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                if (t0 < 0) begin t0 = cyc; y0 = y_out; end
                else begin t1 = cyc; y1 = y_out; end
            end
        end
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        n_checks += 3;
        if (t1 - t0 != 10) begin n_fail++; $display("FAIL b2b_interval: got %0d required 10", t1 - t0); end
        if (y0 !== 16'sd11) begin n_fail++; $display("FAIL b2b_y0: got %0d required 11", y0); end
        if (y1 !== 16'sd11) begin n_fail++; $display("FAIL b2b_y1: got %0d required 11", y1); end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_two_tap();
        test_saturation();
        test_rounding();
        test_backpressure();
        test_reset_mid_mac();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
